// File: rtl/gpio_bus_periph.sv
// Memory-mapped GPIO: output/direction registers, synchronised inputs,
// per-pin edge capture with write-1-to-clear status and a level interrupt.
module gpio_bus_periph #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gpio_ce,
    input  logic             bus_re,
    input  logic [3:0]       bus_we,
    input  logic [31:0]      bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      gpio_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_DIR    = 3'd1;
    localparam logic [2:0] OFF_IN     = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_IEN    = 3'd4;
    localparam logic [2:0] OFF_EDGE   = 3'd5;

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int CW      = $clog2(ARM_MAX + 1);
    localparam logic [CW-1:0] ARM_MAX_C = CW'(ARM_MAX);

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{we[i]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  we);
        logic [31:0] m;
        m = lane_mask(we);
        return (old & ~m) | (wd & m);
    endfunction

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [1:0]       edge_q, edge_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    arm_q, arm_d;

    logic [WIDTH-1:0] sync_out, rise, fall, set_bits, clr_bits;
    logic             armed;
    logic [2:0]       sel;
    logic [31:0]      tmp_out, tmp_dir, tmp_ien, tmp_edge, tmp_clr;
    logic             unused_addr;

    assign unused_addr = ^{bus_addr[31:5], bus_addr[1:0]};
    assign sel         = bus_addr[4:2];
    assign sync_out    = sync_q[SYNC_STAGES-1];
    assign rise        = sync_out & ~prev_q;
    assign fall        = ~sync_out & prev_q;
    // Capture stays off until the chain has flushed post-reset pin levels.
    assign armed       = (arm_q == ARM_MAX_C);
    assign arm_d       = armed ? arm_q : arm_q + 1'b1;
    assign set_bits    = {WIDTH{armed}} &
                         ((rise & {WIDTH{edge_q[0]}}) | (fall & {WIDTH{edge_q[1]}}));

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ien_d    = ien_q;
        edge_d   = edge_q;
        tmp_out  = merge(ext(out_q), bus_wdata, bus_we);
        tmp_dir  = merge(ext(dir_q), bus_wdata, bus_we);
        tmp_ien  = merge(ext(ien_q), bus_wdata, bus_we);
        tmp_edge = merge({30'b0, edge_q}, bus_wdata, bus_we);
        tmp_clr  = '0;
        if (gpio_ce) begin
            case (sel)
                OFF_OUT:    out_d   = tmp_out[WIDTH-1:0];
                OFF_DIR:    dir_d   = tmp_dir[WIDTH-1:0];
                OFF_STATUS: tmp_clr = bus_wdata & lane_mask(bus_we);
                OFF_IEN:    ien_d   = tmp_ien[WIDTH-1:0];
                OFF_EDGE:   edge_d  = tmp_edge[1:0];
                default:    ;
            endcase
        end
        clr_bits = tmp_clr[WIDTH-1:0];
        // A new edge in the same cycle as its clear must not be lost.
        status_d = (status_q & ~clr_bits) | set_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            dir_q    <= '0;
            status_q <= '0;
            ien_q    <= '0;
            edge_q   <= '0;
            prev_q   <= '0;
            arm_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            status_q <= status_d;
            ien_q    <= ien_d;
            edge_q   <= edge_d;
            prev_q   <= sync_out;
            arm_q    <= arm_d;
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        gpio_rdata = '0;
        if (gpio_ce && bus_re) begin
            case (sel)
                OFF_OUT:    gpio_rdata = ext(out_q);
                OFF_DIR:    gpio_rdata = ext(dir_q);
                OFF_IN:     gpio_rdata = ext(sync_out);
                OFF_STATUS: gpio_rdata = ext(status_q);
                OFF_IEN:    gpio_rdata = ext(ien_q);
                OFF_EDGE:   gpio_rdata = {30'b0, edge_q};
                default:    gpio_rdata = '0;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(status_q & ien_q);

endmodule

// File: doc/gpio_bus_periph.md
Name: gpio_bus_periph

Overview:
- Memory-mapped GPIO peripheral. It is the consumer of the bus controller's gpio_ce select, alongside the data RAM on the same CPU data bus (bus_re / bus_we / bus_addr / bus_wdata).
- Provides output drive and direction registers, synchronised pin inputs, per-pin edge capture and a level interrupt.
- Reads are combinational so the single-cycle core completes loads in the same cycle; all register updates occur on the rising clk edge.

Parameters:
- WIDTH, 32: number of GPIO pins (1..32). Register bits at and above WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2: depth of the input synchroniser flop chain (2..4).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- gpio_ce  in  1  peripheral select from the bus controller
- bus_re  in  1  read strobe
- bus_we  in  4  byte-lane write enables; lane i = bits [8i+7:8i]
- bus_addr  in  32  byte address; only [4:2] are decoded
- bus_wdata  in  32  write data
- gpio_rdata  out  32  read data, muxed by the top level with RAM data
- gpio_in  in  WIDTH  asynchronous pin inputs
- gpio_out  out  WIDTH  output values (the OUT register)
- gpio_oe  out  WIDTH  output enables (the DIR register; 1 = drive)
- irq  out  1  interrupt, active-high level

Behaviour:
- Register map, word offsets from bus_addr[4:2]:
  - 0x00 OUT: read/write.
  - 0x04 DIR: read/write.
  - 0x08 IN: read-only; returns the last stage of the synchroniser.
  - 0x0C STATUS: write-1-to-clear edge flags.
  - 0x10 IEN: read/write interrupt enables.
  - 0x14 EDGE: read/write; bit 0 = capture rising edges, bit 1 = capture falling edges on that pin.
  - 0x18 and 0x1C: read 0; writes ignored.
- Write qualification: a write occurs at the rising edge when gpio_ce=1 and bus_we[i]=1; only the enabled byte lanes are updated. bus_re is ignored for writes. Writes to IN are ignored.
- Read qualification: gpio_rdata = selected register when gpio_ce=1 and bus_re=1, else 32'h0. Reads have no side effects.
- Reset (rst=1 at a rising edge) clears:
  - OUT, DIR, STATUS, IEN and EDGE to 0;
  - the synchroniser chain and the previous-sample register to 0;
  - the arm counter to 0.
  - After reset, gpio_out=0, gpio_oe=0, irq=0 and gpio_rdata=0.
  - An assertion mid-operation discards pending edges and any in-flight write.
- Synchroniser: gpio_in passes through SYNC_STAGES flops. A pin change sampled at edge k is readable in IN after edge k+SYNC_STAGES-1.
- Previous-sample register: loads the synchroniser output every cycle.
  - rise = sync & ~prev
  - fall = ~sync & prev
- Arm counter (saturating, 0..SYNC_STAGES+1):
  - Increments each cycle after reset.
  - Edge capture is suppressed until the counter saturates, so pins held high during reset produce no spurious rising edge.
- STATUS update per bit, each cycle:
  - next = (STATUS & ~clr) | set
  - set = armed & ((rise & EDGE[0]) | (fall & EDGE[1])) for that pin
  - clr = W1C mask from the enabled lanes
  - If set and clear coincide on the same bit, set wins.
- irq = |(STATUS & IEN), generated combinationally from registers with no extra delay. Clearing STATUS or IEN drops irq in the cycle after the write edge.
- Latency: pin toggle sampled at edge k → STATUS bit and irq high after edge k+SYNC_STAGES (k+2 by default).
- gpio_out/gpio_oe reflect written values immediately after the write edge. The input path does not loop back internally; IN always reflects the pins.

Test Plan:
- Reset then idle → gpio_out=0, gpio_oe=0, irq=0; reads of all offsets return 0; a pin held at 1 through reset never sets STATUS.
- Write 0x12345678 to OUT with bus_we=4'b0101, then read → 0x00340078; DIR write 0xFFFFFFFF → gpio_oe all 1.
- EDGE=0x1 on pin 3, IEN bit 3=1, gpio_in[3] 0→1 sampled at edge k → IN[3]=1 after edge k+1, STATUS=0x8 and irq=1 after edge k+2; write 0x8 to STATUS → irq=0 next cycle.
- Pin 5 configured for both edges: pulse 0→1→0 held 4 cycles each → STATUS[5] sets; clear it, then a falling edge re-sets it. A W1C write in the same cycle as a new edge leaves STATUS[5]=1.
- gpio_ce=0 with bus_we=4'hF → no register changes, gpio_rdata=0; offset 0x1C read → 0; bus_re=0 with gpio_ce=1 → gpio_rdata=0.
- rst asserted mid-pattern with STATUS=0xFF and irq=1 → next cycle all registers 0, irq=0; edges within SYNC_STAGES+1 cycles after release are ignored.
